// File: rtl/trigger_mux.sv
// trigger_mux: N-source trigger switch with enable mask, per-source prescale,
// dead time and accepted/lost counters. Lost counter is built only with TRIGGER_MUX_LOST_CNT_EN.
module trigger_mux #(
    parameter int N_SRC  = 4,
    parameter int DEAD_W = 16,
    parameter int PRE_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sync,
    input  logic               ctrl_write,
    input  logic [3:0]         ctrl_address,
    input  logic [31:0]        ctrl_writedata,
    input  logic [5*N_SRC-1:0] src_trg,
    output logic [4:0]         dst_trg,
    output logic [3:0]         dst_src,
    output logic               busy,
    output logic [CNT_W-1:0]   acc_count,
    output logic [CNT_W-1:0]   lost_count
);
    localparam int TRG = 1;

    logic [N_SRC-1:0]  mask;
    logic [DEAD_W-1:0] dead_time;
    logic [DEAD_W-1:0] dead_cnt;
    logic [PRE_W-1:0]  pre_k   [N_SRC];
    logic [PRE_W-1:0]  pre_cnt [N_SRC];
    logic [4:0]        src_vec [N_SRC];

    logic             win_found;
    logic [3:0]       win_idx;
    logic [4:0]       win_vec;
    logic [PRE_W-1:0] win_k;
    logic [PRE_W-1:0] win_cnt;
    logic             trg_req;
    logic             pre_pass;
    logic             pre_adv;
    logic             emit;

    logic       wr_mask;
    logic       wr_dead;
    logic       wr_pre;
    logic       wr_clear;
    logic [3:0] wr_idx;
    logic       unused_bits;

    assign wr_mask     = ctrl_write && (ctrl_address == 4'd0);
    assign wr_dead     = ctrl_write && (ctrl_address == 4'd1);
    assign wr_pre      = ctrl_write && (ctrl_address == 4'd2);
    assign wr_clear    = ctrl_write && (ctrl_address == 4'd3);
    assign wr_idx      = ctrl_writedata[19:16];
    assign busy        = (dead_cnt != '0);
    assign unused_bits = ^{ctrl_writedata, win_vec[0]};

    always_comb begin
        for (int s = 0; s < N_SRC; s++) begin
            src_vec[s] = src_trg[5*s +: 5];
        end
    end

    // Scan from the top so the lowest-index enabled, active source wins.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        win_vec   = '0;
        win_k     = '0;
        win_cnt   = '0;
        for (int s = N_SRC - 1; s >= 0; s--) begin
            if (mask[s] && (src_vec[s] != 5'd0)) begin
                win_found = 1'b1;
                win_idx   = 4'(s);
                win_vec   = src_vec[s];
                win_k     = pre_k[s];
                win_cnt   = pre_cnt[s];
            end
        end
        trg_req  = win_found && win_vec[TRG];
        pre_pass = (win_k <= PRE_W'(1)) || (win_cnt == win_k - PRE_W'(1));
        pre_adv  = trg_req && !busy && (win_k > PRE_W'(1));
        emit     = trg_req && !busy && pre_pass;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask      <= '0;
            dead_time <= '0;
            // NOTE: these per-source arrays are flops, not RAM, so a reset loop is legitimate.
            for (int s = 0; s < N_SRC; s++) begin
                pre_k[s]   <= '0;
                pre_cnt[s] <= '0;
            end
        end else begin
            if (wr_mask) mask <= ctrl_writedata[N_SRC-1:0];
            if (wr_dead) dead_time <= ctrl_writedata[DEAD_W-1:0];
            for (int s = 0; s < N_SRC; s++) begin
                if (sync && pre_adv && (win_idx == 4'(s)))
                    pre_cnt[s] <= pre_pass ? '0 : pre_cnt[s] + PRE_W'(1);
                // A prescale write lands after the slot update, so its clear wins.
                if (wr_pre && (wr_idx == 4'(s))) begin
                    pre_k[s]   <= ctrl_writedata[PRE_W-1:0];
                    pre_cnt[s] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_trg   <= '0;
            dst_src   <= '0;
            dead_cnt  <= '0;
            acc_count <= '0;
        end else begin
            // NOTE: non-blocking updates mean a slot on a write edge still sees the old registers.
            if (sync) begin
                dst_trg <= win_found ? {win_vec[4:2], emit, 1'b0} : 5'd0;
                if (win_found) dst_src <= win_idx;
                if (emit)      dead_cnt <= dead_time;
                else if (busy) dead_cnt <= dead_cnt - DEAD_W'(1);
                if (emit && (acc_count != '1)) acc_count <= acc_count + CNT_W'(1);
            end
            if (wr_clear) acc_count <= '0;
        end
    end

`ifdef TRIGGER_MUX_LOST_CNT_EN
    logic lost_flag;

    // Lost: winner blocked by dead time, or any other enabled source asking for trg.
    always_comb begin
        lost_flag = trg_req && busy;
        for (int s = 0; s < N_SRC; s++) begin
            if (mask[s] && src_vec[s][TRG] && (win_idx != 4'(s)))
                lost_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lost_count <= '0;
        end else begin
            if (sync && lost_flag && (lost_count != '1))
                lost_count <= lost_count + CNT_W'(1);
            if (wr_clear) lost_count <= '0;
        end
    end
`else
    assign lost_count = '0;
`endif

endmodule

// File: tb/tb_trigger_mux.sv
// tb_trigger_mux: directed plus randomized checks of trigger_mux against a
// slot-level reference model (dead time tracked as an end slot, prescale as a modulo).
module tb_trigger_mux;
    localparam int N = 4;
    localparam longint MAXC = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          sync;
    logic          ctrl_write;
    logic [3:0]    ctrl_address;
    logic [31:0]   ctrl_writedata;
    logic [5*N-1:0] src_trg;
    logic [4:0]    dst_trg;
    logic [3:0]    dst_src;
    logic          busy;
    logic [31:0]   acc_count;
    logic [31:0]   lost_count;

    int checks = 0;
    int errors = 0;

    trigger_mux #(.N_SRC(N), .DEAD_W(16), .PRE_W(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .sync(sync),
        .ctrl_write(ctrl_write), .ctrl_address(ctrl_address), .ctrl_writedata(ctrl_writedata),
        .src_trg(src_trg), .dst_trg(dst_trg), .dst_src(dst_src), .busy(busy),
        .acc_count(acc_count), .lost_count(lost_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [N-1:0] m_mask;
    int         m_d;
    int         m_k[N];
    int         m_arrive[N];
    longint     m_slot;
    longint     m_end;
    longint     m_acc;
    longint     m_lost;
    logic [4:0] m_trg;
    logic [3:0] m_src;

    function automatic longint exp_lost();
`ifdef TRIGGER_MUX_LOST_CNT_EN
        return m_lost;
`else
        return 0;
`endif
    endfunction

    function automatic bit m_busy();
        return m_slot <= m_end;
    endfunction

    task automatic model_reset();
        m_mask = '0; m_d = 0; m_slot = 0; m_end = -1;
        m_acc = 0; m_lost = 0; m_trg = '0; m_src = '0;
        for (int s = 0; s < N; s++) begin
            m_k[s] = 0;
            m_arrive[s] = 0;
        end
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d);
        int idx;
        idx = int'(d[19:16]);
        case (a)
            4'd0: m_mask = d[N-1:0];
            4'd1: m_d = int'(d[15:0]);
            4'd2: if (idx < N) begin
                      m_k[idx] = int'(d[7:0]);
                      m_arrive[idx] = 0;
                  end
            4'd3: begin m_acc = 0; m_lost = 0; end
            default: ;
        endcase
    endtask

    task automatic model_slot(input logic [5*N-1:0] v);
        int w;
        bit lost;
        bit emitted;
        logic [4:0] sv;
        w = -1; lost = 0; emitted = 0;
        for (int s = 0; s < N; s++) begin
            sv = v[5*s +: 5];
            if (w < 0 && m_mask[s] && sv != 5'd0) w = s;
        end
        for (int s = 0; s < N; s++) begin
            sv = v[5*s +: 5];
            if (m_mask[s] && sv[1] && s != w) lost = 1;
        end
        if (w < 0) begin
            m_trg = 5'd0;
        end else begin
            sv = v[5*w +: 5];
            if (sv[1]) begin
                if (m_slot <= m_end) lost = 1;
                else begin
                    m_arrive[w]++;
                    emitted = (m_k[w] <= 1) || (m_arrive[w] % m_k[w] == 0);
                end
            end
            if (emitted) begin
                m_end = m_slot + m_d;
                if (m_acc < MAXC) m_acc++;
            end
            m_trg = {sv[4:2], emitted, 1'b0};
            m_src = 4'(w);
        end
        if (lost && m_lost < MAXC) m_lost++;
        m_slot++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sync = 1'b0; ctrl_write = 1'b0; src_trg = '0;
        #2;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        ctrl_write = 1'b1; ctrl_address = a; ctrl_writedata = d; sync = 1'b0;
        @(posedge clk);
        #1;
        ctrl_write = 1'b0;
        model_write(a, d);
    endtask

    task automatic run_slot(input logic [5*N-1:0] v);
        @(negedge clk);
        src_trg = v; sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0; src_trg = '0;
        model_slot(v);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (dst_trg !== 5'd0) begin errors++; $display("FAIL reset_dst_trg: got %b expected 00000", dst_trg); end
        checks++; if (dst_src !== 4'd0) begin errors++; $display("FAIL reset_dst_src: got %0d expected 0", dst_src); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (acc_count !== 32'd0) begin errors++; $display("FAIL reset_acc: got %0d expected 0", acc_count); end
        checks++; if (lost_count !== 32'd0) begin errors++; $display("FAIL reset_lost: got %0d expected 0", lost_count); end
    endtask

    task automatic test_basic();
        logic [5*N-1:0] v;
        do_reset();
        reg_write(4'd0, 32'h1);
        v = '0; v[4:0] = 5'b00010;
        for (int i = 0; i < 10; i++) begin
            run_slot(v);
            checks++; if (dst_trg !== 5'b00010 || dst_src !== 4'd0) begin
                errors++; $display("FAIL basic_fwd[%0d]: got trg=%b src=%0d expected trg=00010 src=0", i, dst_trg, dst_src);
            end
        end
        checks++; if (acc_count !== 32'd10) begin errors++; $display("FAIL basic_acc: got %0d expected 10", acc_count); end
        checks++; if (lost_count !== 32'd0) begin errors++; $display("FAIL basic_lost: got %0d expected 0", lost_count); end
    endtask

    task automatic test_arbitration();
        logic [5*N-1:0] v;
        do_reset();
        reg_write(4'd0, 32'hF);
        v = '0; v[9:5] = 5'b00010; v[19:15] = 5'b00010;
        run_slot(v);
        checks++; if (dst_src !== 4'd1) begin errors++; $display("FAIL arb_src: got %0d expected 1", dst_src); end
        checks++; if (dst_trg !== 5'b00010) begin errors++; $display("FAIL arb_trg: got %b expected 00010", dst_trg); end
        checks++; if (acc_count !== 32'd1) begin errors++; $display("FAIL arb_acc: got %0d expected 1", acc_count); end
        checks++; if (lost_count !== 32'(exp_lost())) begin errors++; $display("FAIL arb_lost: got %0d expected %0d", lost_count, exp_lost()); end
    endtask

    task automatic test_dead_time();
        logic [5*N-1:0] v;
        do_reset();
        reg_write(4'd0, 32'h1);
        reg_write(4'd1, 32'd3);
        for (int i = 0; i < 8; i++) begin
            v = '0;
            v[4:0] = (i == 2) ? 5'b10010 : 5'b00010;
            run_slot(v);
            checks++; if (busy !== ((i % 4) != 3)) begin
                errors++; $display("FAIL dead_busy[%0d]: got %b expected %b", i, busy, (i % 4) != 3);
            end
            checks++; if (dst_trg[1] !== ((i % 4) == 0)) begin
                errors++; $display("FAIL dead_emit[%0d]: got %b expected %b", i, dst_trg[1], (i % 4) == 0);
            end
            if (i == 2) begin
                checks++; if (dst_trg !== 5'b10000) begin errors++; $display("FAIL dead_cal: got %b expected 10000", dst_trg); end
            end
        end
        checks++; if (acc_count !== 32'd2) begin errors++; $display("FAIL dead_acc: got %0d expected 2", acc_count); end
`ifdef TRIGGER_MUX_LOST_CNT_EN
        checks++; if (lost_count !== 32'd6) begin errors++; $display("FAIL dead_lost: got %0d expected 6", lost_count); end
`else
        checks++; if (lost_count !== 32'd0) begin errors++; $display("FAIL dead_lost_off: got %0d expected 0", lost_count); end
`endif
    endtask

    task automatic test_prescale();
        logic [5*N-1:0] v;
        do_reset();
        reg_write(4'd0, 32'b0100);
        reg_write(4'd2, (32'd2 << 16) | 32'd4);
        v = '0; v[14:10] = 5'b00010;
        for (int i = 0; i < 12; i++) begin
            run_slot(v);
            checks++; if (dst_trg[1] !== ((i % 4) == 3) || dst_src !== 4'd2) begin
                errors++; $display("FAIL pre_emit[%0d]: got trg=%b src=%0d expected trg=%b src=2", i, dst_trg[1], dst_src, (i % 4) == 3);
            end
        end
        checks++; if (acc_count !== 32'd3) begin errors++; $display("FAIL pre_acc: got %0d expected 3", acc_count); end
        checks++; if (lost_count !== 32'd0) begin errors++; $display("FAIL pre_lost: got %0d expected 0", lost_count); end
    endtask

    task automatic test_reset_mid_dead();
        logic [5*N-1:0] v;
        do_reset();
        reg_write(4'd0, 32'h1);
        reg_write(4'd1, 32'd100);
        v = '0; v[4:0] = 5'b00010;
        for (int i = 0; i < 10; i++) run_slot(v);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (acc_count !== 32'd0) begin errors++; $display("FAIL mid_acc: got %0d expected 0", acc_count); end
        checks++; if (lost_count !== 32'd0) begin errors++; $display("FAIL mid_lost: got %0d expected 0", lost_count); end
        checks++; if (dst_trg !== 5'd0) begin errors++; $display("FAIL mid_trg: got %b expected 00000", dst_trg); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        reg_write(4'd0, 32'h1);
        run_slot(v);
        checks++; if (dst_trg !== 5'b00010 || acc_count !== 32'd1) begin
            errors++; $display("FAIL mid_after: got trg=%b acc=%0d expected trg=00010 acc=1", dst_trg, acc_count);
        end
    endtask

    task automatic test_random();
        logic [5*N-1:0] v;
        logic [31:0]    d;
        logic [3:0]     a;
        int             r;
        do_reset();
        reg_write(4'd0, 32'($urandom_range(1, 15)));
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                a = 4'($urandom_range(0, 5));
                case (a)
                    4'd1:    d = 32'($urandom_range(0, 5));
                    4'd2:    d = (32'($urandom_range(0, 5)) << 16) | 32'($urandom_range(0, 5));
                    default: d = $urandom;
                endcase
                reg_write(a, d);
            end else if (r == 1) begin
                @(negedge clk);
                @(posedge clk);
                #1;
            end else begin
                v = '0;
                for (int s = 0; s < N; s++)
                    if ($urandom_range(0, 2) != 0) v[5*s +: 5] = 5'($urandom_range(0, 31));
                run_slot(v);
            end
            checks++; if (dst_trg !== m_trg) begin errors++; $display("FAIL rnd_trg[%0d]: got %b expected %b", i, dst_trg, m_trg); end
            checks++; if (dst_src !== m_src) begin errors++; $display("FAIL rnd_src[%0d]: got %0d expected %0d", i, dst_src, m_src); end
            checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, busy, m_busy()); end
            checks++; if (acc_count !== 32'(m_acc)) begin errors++; $display("FAIL rnd_acc[%0d]: got %0d expected %0d", i, acc_count, m_acc); end
            checks++; if (lost_count !== 32'(exp_lost())) begin errors++; $display("FAIL rnd_lost[%0d]: got %0d expected %0d", i, lost_count, exp_lost()); end
        end
    endtask

    initial begin
        reset = 1'b1; sync = 1'b0; ctrl_write = 1'b0;
        ctrl_address = '0; ctrl_writedata = '0; src_trg = '0;
        model_reset();
        test_reset();
        test_basic();
        test_arbitration();
        test_dead_time();
        test_prescale();
        test_reset_mid_dead();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
